// File: rtl/mult_csa_pipe.sv
// mult_csa_pipe -- pipelined carry-save array multiplier.
//
// Each of the WIDTH/ROWS carry-save stages folds ROWS partial-product rows
// into a redundant sum/carry pair using 3:2 compressors. No stage has a
// carry-propagate path. A final stage performs the single carry-propagate
// add and registers the product. Total latency is LAT = WIDTH/ROWS + 1.
//
// Signed operands use modified Baugh-Wooley. Partial-product bits that
// involve exactly one operand MSB are inverted. The constant
// 2^WIDTH + 2^(2*WIDTH-1) is preloaded into the first stage's carry
// vector, so the correction costs no extra adder row.
//
// The whole pipeline advances together when the output slot is free or is
// being drained (adv). Otherwise every stage holds, including bubbles.
// Only the valid bits and the output register are reset.
// WIDTH must be >= 4 and divisible by ROWS.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   a/b/sgn carry a new operation
//   in_ready  out  operation accepted this cycle (== adv)
//   a, b      in   WIDTH-bit multiplicand / multiplier
//   sgn       in   1 = two's complement, 0 = unsigned
//   out_valid out  y holds a completed product
//   out_ready in   consumer takes y this cycle
//   y         out  2*WIDTH-bit product
module mult_csa_pipe #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y
);

  localparam int LAT = WIDTH / ROWS + 1;
  localparam int NS  = LAT - 1;
  localparam int PW  = 2 * WIDTH;
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  logic            adv;
  logic            vld_q   [NS];
  logic [WIDTH-1:0] a_q    [NS];
  logic [WIDTH-1:0] b_q    [NS];
  logic            sgn_q   [NS];
  logic [PW-1:0]   sum_q   [NS];
  logic [PW-1:0]   carry_q [NS];
  logic            out_valid_q;
  logic [PW-1:0]   y_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign y         = y_q;

  // Row i of the partial-product array, already shifted into place.
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] m,
                                           input logic s,
                                           input int i);
    logic [PW-1:0] r;
    logic          bit_v;
    r = '0;
    for (int j = 0; j < WIDTH; j++) begin
      bit_v = x[j] & m[i];
      // Baugh-Wooley: invert bits with exactly one MSB factor.
      if (s && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_v = ~bit_v;
      r[i+j] = bit_v;
    end
    return r;
  endfunction

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic             vld_in;
    logic             sgn_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [PW-1:0]    s_in;
    logic [PW-1:0]    c_in;
    logic [PW-1:0]    sum_d;
    logic [PW-1:0]    carry_d;

    if (k == 0) begin : g_first
      assign vld_in = in_valid;
      assign sgn_in = sgn;
      assign a_in   = a;
      assign b_in   = b;
      assign s_in   = '0;
      assign c_in   = sgn ? BW_CORR : '0;
    end else begin : g_next
      assign vld_in = vld_q[k-1];
      assign sgn_in = sgn_q[k-1];
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign s_in   = sum_q[k-1];
      assign c_in   = carry_q[k-1];
    end

    always_comb begin : csa_rows
      logic [PW-1:0] s;
      logic [PW-1:0] c;
      logic [PW-1:0] row;
      logic [PW-1:0] s_n;
      s   = s_in;
      c   = c_in;
      row = '0;
      s_n = '0;
      for (int r = 0; r < ROWS; r++) begin
        row = pp_row(a_in, b_in, sgn_in, k * ROWS + r);
        s_n = s ^ c ^ row;
        c   = ((s & c) | (s & row) | (c & row)) << 1;
        s   = s_n;
      end
      sum_d   = s;
      carry_d = c;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
      end else if (adv) begin
        vld_q[k] <= vld_in;
      end
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        a_q[k]     <= a_in;
        b_q[k]     <= b_in;
        sgn_q[k]   <= sgn_in;
        sum_q[k]   <= sum_d;
        carry_q[k] <= carry_d;
      end
    end
  end

  // Final carry-propagate stage; overflow beyond 2*WIDTH bits is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else if (adv) begin
      out_valid_q <= vld_q[NS-1];
      y_q         <= sum_q[NS-1] + carry_q[NS-1];
    end
  end

endmodule

// File: tb/tb_mult_csa_pipe.sv
// tb_mult_csa_pipe -- directed testbench for mult_csa_pipe, WIDTH=8, ROWS=2.
module tb_mult_csa_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;

  int errors = 0;
  int checks = 0;

  mult_csa_pipe #(.WIDTH(8), .ROWS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] m,
                                           input logic s);
    logic signed [15:0] xs;
    logic signed [15:0] ms;
    logic signed [15:0] ps;
    logic [15:0]        pu;
    if (s) begin
      xs = {{8{x[7]}}, x};
      ms = {{8{m[7]}}, m};
      ps = xs * ms;
      return ps;
    end
    pu = {8'h00, x} * {8'h00, m};
    return pu;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 8'd7; b = 8'd9; sgn = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (y !== 16'h0000) begin errors++; $display("FAIL reset_y got=%h want=0000", y); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_input_ignored cycle=%0d out_valid=%b want=0", i, out_valid);
      end
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; a = 8'd255; b = 8'd255; sgn = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (out_valid !== ((e == 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL basic_latency edge=%0d out_valid=%b", e, out_valid);
      end
      if (e == 4) begin
        checks++;
        if (y !== 16'hFE01) begin errors++; $display("FAIL basic_y got=%h want=fe01", y); end
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic        vs [3];
    logic [15:0] vy [3];
    va[0] = 8'h80; vb[0] = 8'h80; vs[0] = 1'b1; vy[0] = 16'h4000;
    va[1] = 8'hFF; vb[1] = 8'h01; vs[1] = 1'b1; vy[1] = 16'hFFFF;
    va[2] = 8'hFF; vb[2] = 8'h01; vs[2] = 1'b0; vy[2] = 16'h00FF;
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      a = va[v]; b = vb[v]; sgn = vs[v]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int e = 1; e <= 4; e++) step();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL signed_valid vec=%0d got=%b want=1", v, out_valid); end
      checks++;
      if (y !== vy[v]) begin errors++; $display("FAIL signed_y vec=%0d got=%h want=%h", v, y, vy[v]); end
      step();
    end
  endtask

  task automatic test_stream();
    logic [31:0] st;
    logic [15:0] q[$];
    logic [15:0] exp_y;
    int sent, got, prev, gaps;
    st = 32'h1234_5678; sent = 0; got = 0; prev = -1; gaps = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 140 && got < 100; cyc++) begin
      if (sent < 100) begin
        st = st ^ (st << 13); st = st ^ (st >> 17); st = st ^ (st << 5);
        a = st[7:0]; b = st[15:8]; sgn = st[16]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra cycle=%0d y=%h want=no result", cyc, y);
        end else begin
          exp_y = q.pop_front();
          if (y !== exp_y) begin errors++; $display("FAIL stream_y idx=%0d got=%h want=%h", got, y, exp_y); end
        end
        if (prev >= 0 && cyc != prev + 1) gaps++;
        prev = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_prod(a, b, sgn));
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 100) begin errors++; $display("FAIL stream_count got=%0d want=100", got); end
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL stream_throughput gaps=%0d want=0", gaps); end
  endtask

  task automatic test_back_to_back_stall();
    logic [15:0] q[$];
    logic [15:0] exp_y;
    logic [7:0]  opa, opb;
    int sent, got;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      out_ready = (cyc >= 6 && cyc <= 12) ? 1'b0 : 1'b1;
      if (sent < 10) begin
        opa = 8'(17 * sent + 3); opb = 8'(200 - 13 * sent);
        a = opa; b = opb; sgn = sent[0]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_ready == 1'b0 && out_valid === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", cyc, in_ready); end
        checks++;
        if (q.size() == 0 || y !== q[0]) begin
          errors++; $display("FAIL bp_hold cycle=%0d y=%h", cyc, y);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra cycle=%0d y=%h want=no result", cyc, y);
        end else begin
          exp_y = q.pop_front();
          if (y !== exp_y) begin errors++; $display("FAIL bp_y idx=%0d got=%h want=%h", got, y, exp_y); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_prod(a, b, sgn));
        sent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 10 || q.size() != 0) begin
      errors++; $display("FAIL bp_count got=%0d pending=%0d want=10/0", got, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; sgn = 1'b0; b = 8'd2;
    for (int i = 1; i <= 3; i++) begin
      a = 8'(i); in_valid = 1'b1;
      step();
    end
    rst_n = 1'b0; a = 8'd9; b = 8'd9;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
    a = 8'd3; b = 8'd4; sgn = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (out_valid !== ((e == 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL mid_stale edge=%0d out_valid=%b", e, out_valid);
      end
      if (e == 4) begin
        checks++;
        if (y !== 16'd12) begin errors++; $display("FAIL mid_y got=%0d want=12", y); end
      end
    end
  endtask

  task automatic test_bubbles();
    logic [3:0] pat;
    logic       want;
    pat = 4'b1001;
    out_ready = 1'b1; sgn = 1'b0;
    for (int t = 0; t < 12; t++) begin
      in_valid = (t < 4) ? pat[t] : 1'b0;
      a = 8'(t + 5); b = 8'd10;
      step();
      if (t >= 4) begin
        want = (t - 4 < 4) ? pat[t-4] : 1'b0;
        checks++;
        if (out_valid !== want) begin
          errors++; $display("FAIL bubble_valid t=%0d got=%b want=%b", t, out_valid, want);
        end
        if (want) begin
          checks++;
          if (y !== 16'((t - 4 + 5) * 10)) begin
            errors++; $display("FAIL bubble_y t=%0d got=%0d want=%0d", t, y, (t - 4 + 5) * 10);
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stream();
    test_back_to_back_stall();
    test_reset_midflight();
    test_bubbles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_csa_pipe.md
MULT_CSA_PIPE -- requirements
Module: mult_csa_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be >= 4 and divisible by ROWS.
REQ-002 Parameter ROWS, default 4: partial-product rows reduced per carry-save pipeline stage.
REQ-003 Derived constant LAT = WIDTH/ROWS + 1 SHALL be the stage count: carry-save stages plus one final carry-propagate stage.
REQ-004 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 in_valid  input  1: a, b and sgn hold a new operation.
REQ-007 in_ready  output  1: the block accepts an operation this cycle.
REQ-008 a  input  WIDTH: multiplicand.
REQ-009 b  input  WIDTH: multiplier.
REQ-010 sgn  input  1: 1 = two's-complement operands, 0 = unsigned operands.
REQ-011 out_valid  output  1: y holds a completed product.
REQ-012 out_ready  input  1: the consumer takes y this cycle.
REQ-013 y  output  2*WIDTH: product.

Function
REQ-014 Pipeline advance: adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-015 Accept: when in_valid && in_ready, a, b and sgn SHALL be captured into stage 1 together with valid = 1.
REQ-016 When adv = 1 and in_valid = 0, stage 1 SHALL load valid = 0; its data bits are don't-care.
REQ-017 When adv = 0, every stage register, including valid bits and data, SHALL hold its value.
REQ-018 Stage k (1..WIDTH/ROWS) SHALL add ROWS partial-product rows, b[i] ? a<<i, into the running sum/carry vector pair using 3:2 carry-save adders. Each stage SHALL contain no carry-propagate path.
REQ-019 Sum and carry vectors SHALL each be 2*WIDTH bits wide; a, b and sgn SHALL travel with each valid operation.
REQ-020 Signed mode SHALL use Baugh-Wooley correction: invert the MSB-row and MSB-column partial-product bits, and add constants 1<<WIDTH and 1<<(2*WIDTH-1).
REQ-021 Unsigned mode SHALL apply no correction, and sgn may differ between back-to-back operations.
REQ-022 The final stage SHALL register y = sum + carry, mod 2^(2*WIDTH), and set out_valid.
REQ-023 Exact product: the result SHALL equal the exact product; the signed result is the two's-complement product, with no overflow possible.
REQ-024 Latency: with out_ready held at 1, an operation accepted at edge n SHALL appear with out_valid = 1 after edge n+LAT-1, that is LAT cycles from accept to visibility.
REQ-025 Throughput: one operation per cycle SHALL be sustained while out_ready = 1.
REQ-026 Ordering: results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-027 Backpressure: while out_valid && !out_ready, y and out_valid SHALL remain stable.
REQ-028 Bubbles (invalid stages) SHALL still advance and are not compressed while adv = 0.

Reset
REQ-029 With rst_n = 0 at a rising edge, all stage valid bits and out_valid SHALL become 0, and y SHALL become 0.
REQ-030 Data pipeline registers other than valid bits need not be reset.
REQ-031 Reset SHALL take priority over accept and advance; operations in flight at reset SHALL be discarded, and no stale result SHALL appear afterwards.
REQ-032 During reset, in_ready SHALL equal 1, since out_valid = 0; inputs offered in a reset cycle SHALL be ignored.

Verification
REQ-033 Bench parameters: WIDTH=8, ROWS=2, so LAT=5.
REQ-034 Basic: out_ready=1; accept a=255, b=255, sgn=0 -> y=65025 (0xFE01) with out_valid=1 exactly 5 cycles after accept.
REQ-035 Signed: a=0x80, b=0x80, sgn=1 -> y=0x4000. Then a=0xFF, b=0x01, sgn=1 -> y=0xFFFF. The same a=0xFF, b=0x01 with sgn=0 -> y=0x00FF.
REQ-036 Streaming: 100 xorshift operand pairs on consecutive cycles with random sgn -> 100 results in order, each equal to the reference product, one per cycle.
REQ-037 Backpressure: stream 10 operations and drop out_ready for 7 cycles mid-stream -> in_ready=0 while stalled, y held stable, all 10 results correct and in order.
REQ-038 Reset mid-flight: accept 3 operations, assert rst_n=0 for 1 cycle, then accept a=3, b=4, sgn=0 -> the only result is y=12, 5 cycles after that accept, and no earlier out_valid pulse appears.
REQ-039 Bubbles: in_valid toggles 1,0,0,1 with out_ready=1 -> out_valid follows the pattern 1,0,0,1 delayed by 5 cycles.
